// File: rtl/overlay_ctrl.sv
// ---------------------------------------------------------------------------
// overlay_ctrl
//   Job sequencer for the PE-array overlay. A job first forwards the
//   instruction chain (NUM_PE*INST_PER_PE words) from the instruction
//   stream onto inst_v/inst_in. It then forwards cfg_len data words from the
//   data stream onto din_v/din_ld. Finally it waits for the PE pipeline to
//   empty and pulses done for one cycle.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   start, abort, cfg_len        job control; cfg_len is latched at start
//   inst_s_valid/ready/data      instruction source handshake
//   data_s_valid/ready/data      data source handshake
//   inst_v, inst_in              registered instruction load into the chain
//   din_v, din_ld                registered data load into the array
//   res_v                        din_v delayed by PIPE_LAT cycles
//   busy                         high whenever a job is in progress
//   done                         one-cycle job-complete pulse
// ---------------------------------------------------------------------------
module overlay_ctrl #(
    parameter int NUM_PE      = 8,
    parameter int INST_PER_PE = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int INST_WIDTH  = 32,
    parameter int PIPE_LAT    = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [15:0]             cfg_len,
    input  logic                    inst_s_valid,
    output logic                    inst_s_ready,
    input  logic [INST_WIDTH-1:0]   inst_s_data,
    input  logic                    data_s_valid,
    output logic                    data_s_ready,
    input  logic [2*DATA_WIDTH-1:0] data_s_data,
    output logic                    inst_v,
    output logic [INST_WIDTH-1:0]   inst_in,
    output logic                    din_v,
    output logic [2*DATA_WIDTH-1:0] din_ld,
    output logic                    res_v,
    output logic                    busy,
    output logic                    done
);

    localparam int INST_TOTAL = NUM_PE * INST_PER_PE;
    localparam int ICNT_W     = $clog2(INST_TOTAL + 1);
    localparam logic [ICNT_W-1:0] INST_LAST = ICNT_W'(INST_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_INST = 2'd1,
        STREAM    = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ICNT_W-1:0]   inst_cnt;
    logic [15:0]         data_cnt;
    logic [15:0]         len;
    logic [PIPE_LAT-1:0] res_sr;
    logic                inst_hs;
    logic                data_hs;
    logic                kill;
    logic                drained;

    assign inst_hs = inst_s_valid & inst_s_ready;
    assign data_hs = data_s_valid & data_s_ready;
    assign kill    = abort & (state != IDLE);
    // The pipeline is empty only when nothing is in flight in the delay line
    // and no load is being presented to the array this cycle.
    assign drained = (res_sr == '0) & ~din_v;
    assign busy    = (state != IDLE);
    assign res_v   = res_sr[PIPE_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        inst_s_ready = 1'b0;
        data_s_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start && (cfg_len != 16'd0)) state_nxt = LOAD_INST;
            end
            LOAD_INST: begin
                inst_s_ready = 1'b1;
                if (inst_s_valid && (inst_cnt == INST_LAST)) state_nxt = STREAM;
            end
            STREAM: begin
                data_s_ready = 1'b1;
                if (data_s_valid && (data_cnt == len - 16'd1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drained) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Cancel wins over any phase transition decided above.
        if (kill) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_cnt <= '0;
            data_cnt <= '0;
            len      <= '0;
            res_sr   <= '0;
            inst_v   <= 1'b0;
            inst_in  <= '0;
            din_v    <= 1'b0;
            din_ld   <= '0;
            done     <= 1'b0;
        end else begin
            inst_v <= 1'b0;
            din_v  <= 1'b0;
            done   <= 1'b0;
            res_sr <= {res_sr[PIPE_LAT-2:0], din_v};
            if (kill) begin
                // A word handshaken in this cycle is consumed but dropped.
                res_sr <= '0;
            end else begin
                if ((state == IDLE) && start) begin
                    if (cfg_len == 16'd0) begin
                        done <= 1'b1;
                    end else begin
                        len      <= cfg_len;
                        inst_cnt <= '0;
                        data_cnt <= '0;
                    end
                end
                if (inst_hs) begin
                    inst_v   <= 1'b1;
                    inst_in  <= inst_s_data;
                    inst_cnt <= inst_cnt + ICNT_W'(1);
                end
                if (data_hs) begin
                    din_v    <= 1'b1;
                    din_ld   <= data_s_data;
                    data_cnt <= data_cnt + 16'd1;
                end
                if ((state == DRAIN) && drained) done <= 1'b1;
            end
        end
    end

    a_one_ready : assert property (@(posedge clk) disable iff (rst)
        !(inst_s_ready && data_s_ready));
    a_one_load : assert property (@(posedge clk) disable iff (rst)
        !(inst_v && din_v));

endmodule

// File: tb/tb_overlay_ctrl.sv
// ---------------------------------------------------------------------------
// tb_overlay_ctrl
//   Bench for overlay_ctrl. Source words are queued by the scenario tasks,
//   which push the expected forwarded words onto expected queues. A negedge
//   monitor records what the DUT emits; each task pops its expected values
//   and compares them against the recorded output.
// ---------------------------------------------------------------------------
module tb_overlay_ctrl;

    localparam int NI = 32;
    localparam int PL = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_len = 16'd0;
    logic        inst_s_valid = 1'b0;
    logic        inst_s_ready;
    logic [31:0] inst_s_data = 32'd0;
    logic        data_s_valid = 1'b0;
    logic        data_s_ready;
    logic [31:0] data_s_data = 32'd0;
    logic        inst_v;
    logic [31:0] inst_in;
    logic        din_v;
    logic [31:0] din_ld;
    logic        res_v;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    overlay_ctrl #(
        .NUM_PE(8), .INST_PER_PE(4), .DATA_WIDTH(16), .INST_WIDTH(32), .PIPE_LAT(PL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_len(cfg_len),
        .inst_s_valid(inst_s_valid), .inst_s_ready(inst_s_ready), .inst_s_data(inst_s_data),
        .data_s_valid(data_s_valid), .data_s_ready(data_s_ready), .data_s_data(data_s_data),
        .inst_v(inst_v), .inst_in(inst_in), .din_v(din_v), .din_ld(din_ld),
        .res_v(res_v), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;

    // Source streams and monitor records
    int          cyc = 0;
    bit          hs_i = 1'b0;
    bit          hs_d = 1'b0;
    bit          gaps = 1'b0;
    logic [31:0] src_inst[$];
    logic [31:0] src_data[$];
    int          inst_rd = 0;
    int          data_rd = 0;
    logic [31:0] obs_inst[$];
    logic [31:0] obs_din[$];
    int          obs_din_cyc[$];
    int          obs_res_cyc[$];
    int          done_cyc[$];
    int          overlap = 0;

    // Scoreboard (owned by the scenario tasks)
    logic [31:0] exp_inst[$];
    logic [31:0] exp_din[$];
    int          oi = 0;
    int          od = 0;
    int          ores = 0;

    always @(posedge clk) begin
        cyc  = cyc + 1;
        hs_i = inst_s_valid && inst_s_ready && !rst;
        hs_d = data_s_valid && data_s_ready && !rst;
    end

    always @(negedge clk) begin
        if (hs_i) inst_rd++;
        if (hs_d) data_rd++;
        if (inst_v) obs_inst.push_back(inst_in);
        if (din_v) begin
            obs_din.push_back(din_ld);
            obs_din_cyc.push_back(cyc);
        end
        if (res_v) obs_res_cyc.push_back(cyc);
        if (done) done_cyc.push_back(cyc);
        if (inst_v && din_v) overlap++;
        if (inst_rd < src_inst.size() && (!gaps || $urandom_range(0, 1) == 1)) begin
            inst_s_valid = 1'b1;
            inst_s_data  = src_inst[inst_rd];
        end else begin
            inst_s_valid = 1'b0;
            inst_s_data  = $urandom();
        end
        if (data_rd < src_data.size() && (!gaps || $urandom_range(0, 1) == 1)) begin
            data_s_valid = 1'b1;
            data_s_data  = src_data[data_rd];
        end else begin
            data_s_valid = 1'b0;
            data_s_data  = $urandom();
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic queue_job(input int nd);
        logic [31:0] w;
        for (int k = 0; k < NI; k++) begin
            w = $urandom() | 32'd1;
            src_inst.push_back(w);
            exp_inst.push_back(w);
        end
        for (int k = 0; k < nd; k++) begin
            w = $urandom() | 32'd1;
            src_data.push_back(w);
            exp_din.push_back(w);
        end
    endtask

    task automatic pulse_start(input logic [15:0] l);
        start   = 1'b1;
        cfg_len = l;
        tick();
        start   = 1'b0;
        cfg_len = 16'($urandom());
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n0;
        n0 = done_cyc.size();
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cyc.size() != n0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        tick();
        checks++;
        if ({inst_s_ready, data_s_ready, inst_v, din_v, res_v, busy, done} !== 7'd0 ||
            inst_in !== 32'd0 || din_ld !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b%b iv=%b dv=%b rv=%b busy=%b done=%b want all 0",
                     inst_s_ready, data_s_ready, inst_v, din_v, res_v, busy, done);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || inst_s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%b inst_s_ready=%b want 0 0", busy, inst_s_ready);
        end
    endtask

    task automatic test_full_job(input string tag, input bit use_gaps, input int nd, input int budget);
        int  d0;
        int  r0;
        bit  ok;
        logic [31:0] w;
        gaps = use_gaps;
        d0 = done_cyc.size();
        r0 = obs_res_cyc.size();
        queue_job(nd);
        tick();
        pulse_start(16'(nd));
        wait_done(budget, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done_timeout got no done want done within %0d cycles", tag, budget);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_at_done got %b want 0", tag, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_width got %b want 0", tag, done);
        end
        repeat (5) tick();
        checks++;
        if (done_cyc.size() - d0 != 1) begin
            errors++;
            $display("FAIL %s_done_count got %0d want 1", tag, done_cyc.size() - d0);
        end
        checks++;
        if (obs_inst.size() - oi != NI) begin
            errors++;
            $display("FAIL %s_inst_count got %0d want %0d", tag, obs_inst.size() - oi, NI);
        end
        while (exp_inst.size() > 0) begin
            w = exp_inst.pop_front();
            checks++;
            if (oi >= obs_inst.size() || obs_inst[oi] !== w) begin
                errors++;
                $display("FAIL %s_inst_word[%0d] got %h want %h", tag, oi,
                         (oi < obs_inst.size()) ? obs_inst[oi] : 32'hx, w);
            end
            oi++;
        end
        checks++;
        if (obs_din.size() - od != nd) begin
            errors++;
            $display("FAIL %s_din_count got %0d want %0d", tag, obs_din.size() - od, nd);
        end
        checks++;
        if (obs_res_cyc.size() - r0 != nd) begin
            errors++;
            $display("FAIL %s_res_count got %0d want %0d", tag, obs_res_cyc.size() - r0, nd);
        end
        while (exp_din.size() > 0) begin
            w = exp_din.pop_front();
            checks++;
            if (od >= obs_din.size() || obs_din[od] !== w) begin
                errors++;
                $display("FAIL %s_din_word[%0d] got %h want %h", tag, od,
                         (od < obs_din.size()) ? obs_din[od] : 32'hx, w);
            end
            checks++;
            if (od >= obs_din_cyc.size() || ores >= obs_res_cyc.size() ||
                obs_res_cyc[ores] != obs_din_cyc[od] + PL) begin
                errors++;
                $display("FAIL %s_res_timing[%0d] got cycle %0d want din cycle + %0d", tag, od,
                         (ores < obs_res_cyc.size()) ? obs_res_cyc[ores] : -1, PL);
            end
            od++;
            ores++;
        end
        gaps = 1'b0;
    endtask

    task automatic test_zero_len();
        int i0;
        int d0;
        i0 = obs_inst.size();
        d0 = obs_din.size();
        tick();
        pulse_start(16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done got done=%b busy=%b want 1 0", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done_width got %b want 0", done);
        end
        repeat (5) tick();
        checks++;
        if (obs_inst.size() != i0 || obs_din.size() != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_no_loads got inst=%0d din=%0d busy=%b want 0 0 0",
                     obs_inst.size() - i0, obs_din.size() - d0, busy);
        end
    endtask

    task automatic test_abort();
        int  bd;
        int  d0;
        int  r0;
        int  n;
        bit  hit;
        logic [31:0] w;
        bd = data_rd;
        d0 = done_cyc.size();
        r0 = obs_res_cyc.size();
        queue_job(3);
        w = exp_din.pop_back();
        tick();
        pulse_start(16'd10);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (data_rd == bd + 2) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort_reach_word3 got %0d data words want 2", data_rd - bd);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || din_v !== 1'b0 || res_v !== 1'b0 || data_s_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_next_cycle got busy=%b din_v=%b res_v=%b rdy=%b want 0 0 0 0",
                     busy, din_v, res_v, data_s_ready);
        end
        repeat (20) tick();
        checks++;
        if (data_rd - bd != 3) begin
            errors++;
            $display("FAIL abort_word_consumed got %0d want 3", data_rd - bd);
        end
        checks++;
        if (obs_res_cyc.size() != r0) begin
            errors++;
            $display("FAIL abort_res_flushed got %0d res_v pulses want 0", obs_res_cyc.size() - r0);
        end
        checks++;
        if (done_cyc.size() != d0) begin
            errors++;
            $display("FAIL abort_no_done got %0d done pulses want 0", done_cyc.size() - d0);
        end
        n = obs_din.size() - od;
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL abort_din_count got %0d want 2", n);
        end
        while (exp_din.size() > 0) begin
            w = exp_din.pop_front();
            checks++;
            if (od >= obs_din.size() || obs_din[od] !== w) begin
                errors++;
                $display("FAIL abort_din_word[%0d] got %h want %h", od,
                         (od < obs_din.size()) ? obs_din[od] : 32'hx, w);
            end
            od++;
        end
        exp_inst.delete();
        oi   = obs_inst.size();
        od   = obs_din.size();
        ores = obs_res_cyc.size();
        test_full_job("abort_restart", 1'b0, 2, 300);
    endtask

    task automatic test_start_while_busy();
        int  bd;
        int  d0;
        int  n;
        bit  ok;
        bd = data_rd;
        d0 = done_cyc.size();
        queue_job(3);
        tick();
        pulse_start(16'd3);
        repeat (3) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_during_job got %b want 1", busy);
        end
        pulse_start(16'd7);
        wait_done(300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL busy_start_timeout got no done want done within 300 cycles");
        end
        repeat (3) tick();
        n = obs_din.size() - od;
        checks++;
        if (n != 3 || data_rd - bd != 3) begin
            errors++;
            $display("FAIL busy_start_len got din=%0d consumed=%0d want 3 3", n, data_rd - bd);
        end
        checks++;
        if (done_cyc.size() - d0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_done got %0d pulses busy=%b want 1 0",
                     done_cyc.size() - d0, busy);
        end
        exp_inst.delete();
        exp_din.delete();
        oi   = obs_inst.size();
        od   = obs_din.size();
        ores = obs_res_cyc.size();
    endtask

    task automatic test_reset_mid_stream();
        bit hit;
        queue_job(0);
        tick();
        pulse_start(16'd5);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (data_s_ready === 1'b1) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_mid_reach_stream got data_s_ready=%b want 1", data_s_ready);
        end
        checks++;
        if (inst_in === 32'd0) begin
            errors++;
            $display("FAIL rst_mid_last_inst got %h want nonzero word", inst_in);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({inst_s_ready, data_s_ready, inst_v, din_v, res_v, busy, done} !== 7'd0 ||
            inst_in !== 32'd0 || din_ld !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got rdy=%b%b busy=%b inst_in=%h want 0",
                     inst_s_ready, data_s_ready, busy, inst_in);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || data_s_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release got busy=%b data_s_ready=%b want 0 0", busy, data_s_ready);
        end
        exp_inst.delete();
        exp_din.delete();
        oi   = obs_inst.size();
        od   = obs_din.size();
        ores = obs_res_cyc.size();
    endtask

    initial begin
        test_reset();
        test_full_job("full", 1'b0, 5, 300);
        test_full_job("gaps", 1'b1, 20, 1000);
        test_zero_len();
        test_abort();
        test_start_while_busy();
        test_reset_mid_stream();
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL load_overlap got %0d cycles with inst_v and din_v want 0", overlap);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
